exe_mem_stage: RTL and testbench
================================

EXE_MEM_STAGE -- requirements
Module: exe_mem_stage

Interface
REQ-001 Parameter WIDTH, default 16, datapath width of operands, immediate, result and memory address.
REQ-002 Parameter MEM_ABITS, default 12, data-memory address bits; memory is 2^MEM_ABITS words x 12 bits.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  rising-edge system clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 op_a  in  16  first register operand; also the memory address source.
REQ-007 op_b  in  16  second operand; its low 12 bits are the store data.
REQ-008 imm  in  16  immediate value.
REQ-009 imm_sel  in  1  1 = ALU input A is imm, 0 = op_a.
REQ-010 alu_sel  in  4  ALU operation select.
REQ-011 destiny  in  4  destination register index.
REQ-012 write_back  in  1  register write-back enable.
REQ-013 mem_wr / mem_rd  in  1 each  data-memory write / read request.
REQ-014 alu_result  out  16  combinational ALU result; nop_flag  out  1  combinational NOP indicator.
REQ-015 result_q  out  16, destiny_q  out  4, write_back_q  out  1, mem_rd_q  out  1, mem_wr_q  out  1, dir_mem_q  out  16: EXE/MEM pipeline register outputs.
REQ-016 mem_dout  out  12  port-A read data.
REQ-017 vga_addr  in  16, vga_rden  in  1, vga_dout  out  12: read-only port B.

Function
REQ-018 ALU input A = imm_sel ? imm : op_a; input B = op_b; all arithmetic is modulo 2^16.
REQ-019 alu_sel: 0000 ADD A+B; 0001 SUB A-B; 0010 AND; 0011 OR; 0100 XOR; 0101 SLL A<<B[3:0]; 0110 SRL A>>B[3:0] (logical); 0111 pass A; 1000 pass B; 1001 MUL (low 16 bits of A*B).
REQ-020 alu_sel 1111 or any undefined code: alu_result = 0, nop_flag = 1; otherwise nop_flag = 0.
REQ-021 On each rising clock edge, the pipeline register captures alu_result, destiny, write_back, mem_rd, mem_wr, op_a (as dir_mem), and op_b[11:0] (internal store data).
REQ-022 Packed view exe_mem_out[38:0] = {dir_mem_q, mem_wr_q, mem_rd_q, write_back_q, destiny_q, result_q}.
REQ-023 Port A sees dir_mem_q[MEM_ABITS-1:0], mem_wr_q, mem_rd_q and registered store data; upper address bits are ignored (wrap-around).
REQ-024 Port A samples address, write enable and data on the rising edge; if mem_wr_q = 1, the word is written at that edge.
REQ-025 Port A read: if mem_rd_q = 1 at the rising edge, mem_dout updates on the following falling edge; otherwise mem_dout holds its value.
REQ-026 Simultaneous mem_wr_q and mem_rd_q: the write is performed and mem_dout returns the old word (read-before-write).
REQ-027 Port B: vga_addr is sampled on the rising edge when vga_rden = 1; vga_dout updates on the following falling edge; port B never writes.
REQ-028 Port A writing address X while port B reads X on the same edge: vga_dout returns the old word.
REQ-029 Total latency from EX inputs to mem_dout is 1 rising edge (register), then the next rising edge (memory sample), then a falling edge (mem_dout valid).

Reset
REQ-030 While rst_n = 0: all pipeline register outputs = 0, mem_dout = 0, vga_dout = 0; memory writes are suppressed.
REQ-031 Memory array contents are not reset and are preserved across reset.
REQ-032 Reset asserted mid-operation clears any pending write/read immediately; the first capture occurs at the first rising edge after rst_n = 1.

Verification
REQ-033 alu_sel=0000, op_a=3, op_b=4, imm_sel=0 -> alu_result=7; result_q=7 after the next edge.
REQ-034 alu_sel=0001, op_a=5, op_b=7 -> alu_result=0xFFFE; alu_sel=1111 -> alu_result=0, nop_flag=1.
REQ-035 imm_sel=1, imm=0x0010, op_a=0x1234, op_b=1, alu_sel=0000 -> alu_result=0x0011; dir_mem_q=0x1234 after the edge.
REQ-036 Store op_a=0x0005, op_b=0x0ABC, mem_wr=1; then load op_a=0x0005, mem_rd=1 -> mem_dout=0xABC at the falling edge after the memory-sample edge; vga_addr=5 with vga_rden=1 -> vga_dout=0xABC.
REQ-037 Assert rst_n=0 between edges with mem_wr=1 pending -> all outputs 0 immediately and the target word is unchanged; after release, the pipeline resumes on the next edge.

Source files
------------

// File: rtl/exe_mem_stage.sv
// Execute stage ALU, EXE/MEM pipeline register and a 12-bit data memory.
// Port A serves the pipeline read/write path. Port B is a read-only display port.
module exe_mem_stage #(
    parameter int WIDTH     = 16,
    parameter int MEM_ABITS = 12
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic [WIDTH-1:0]     imm,
    input  logic                 imm_sel,
    input  logic [3:0]           alu_sel,
    input  logic [3:0]           destiny,
    input  logic                 write_back,
    input  logic                 mem_wr,
    input  logic                 mem_rd,
    output logic [WIDTH-1:0]     alu_result,
    output logic                 nop_flag,
    output logic [WIDTH-1:0]     result_q,
    output logic [3:0]           destiny_q,
    output logic                 write_back_q,
    output logic                 mem_rd_q,
    output logic                 mem_wr_q,
    output logic [WIDTH-1:0]     dir_mem_q,
    output logic [2*WIDTH+6:0]   exe_mem_out,
    output logic [11:0]          mem_dout,
    input  logic [WIDTH-1:0]     vga_addr,
    input  logic                 vga_rden,
    output logic [11:0]          vga_dout
);

    localparam int DATA_W = 12;
    localparam int DEPTH  = 2 ** MEM_ABITS;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_PASSA = 4'b0111;
    localparam logic [3:0] ALU_PASSB = 4'b1000;
    localparam logic [3:0] ALU_MUL   = 4'b1001;

    logic [WIDTH-1:0]     alu_a_s;
    logic [2*WIDTH-1:0]   mul_full_s;
    logic [DATA_W-1:0]    store_data_r;
    logic [MEM_ABITS-1:0] addr_a_s;
    logic [MEM_ABITS-1:0] addr_b_s;
    logic [DATA_W-1:0]    mem_r [DEPTH];
    logic                 rd_a_pend_r;
    logic [DATA_W-1:0]    rd_a_data_r;
    logic                 rd_b_pend_r;
    logic [DATA_W-1:0]    rd_b_data_r;
    logic                 tie_unused_s;

    // Operand A selection between register operand and immediate
    always_comb begin
        alu_a_s = op_a;
        if (imm_sel) begin
            alu_a_s = imm;
        end else begin
            alu_a_s = op_a;
        end
    end

    assign mul_full_s = {{WIDTH{1'b0}}, alu_a_s} * {{WIDTH{1'b0}}, op_b};

    // ALU operation decode; every unlisted code is a NOP producing zero
    always_comb begin
        alu_result = {WIDTH{1'b0}};
        nop_flag   = 1'b0;
        case (alu_sel)
            ALU_ADD:   alu_result = alu_a_s + op_b;
            ALU_SUB:   alu_result = alu_a_s - op_b;
            ALU_AND:   alu_result = alu_a_s & op_b;
            ALU_OR:    alu_result = alu_a_s | op_b;
            ALU_XOR:   alu_result = alu_a_s ^ op_b;
            ALU_SLL:   alu_result = alu_a_s << op_b[3:0];
            ALU_SRL:   alu_result = alu_a_s >> op_b[3:0];
            ALU_PASSA: alu_result = alu_a_s;
            ALU_PASSB: alu_result = op_b;
            ALU_MUL:   alu_result = mul_full_s[WIDTH-1:0];
            default: begin
                alu_result = {WIDTH{1'b0}};
                nop_flag   = 1'b1;
            end
        endcase
    end

    // EXE/MEM pipeline register; reset drops any pending memory request
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            result_q     <= {WIDTH{1'b0}};
            destiny_q    <= 4'b0000;
            write_back_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            dir_mem_q    <= {WIDTH{1'b0}};
            store_data_r <= {DATA_W{1'b0}};
        end else begin
            result_q     <= alu_result;
            destiny_q    <= destiny;
            write_back_q <= write_back;
            mem_rd_q     <= mem_rd;
            mem_wr_q     <= mem_wr;
            dir_mem_q    <= op_a;
            store_data_r <= op_b[DATA_W-1:0];
        end
    end

    assign exe_mem_out = {dir_mem_q, mem_wr_q, mem_rd_q, write_back_q, destiny_q, result_q};

    // Upper address bits wrap around the memory
    assign addr_a_s = dir_mem_q[MEM_ABITS-1:0];
    assign addr_b_s = vga_addr[MEM_ABITS-1:0];

    // Port A write; the array itself is never cleared so contents survive reset
    always_ff @(posedge clock) begin
        if (rst_n && mem_wr_q) begin
            mem_r[addr_a_s] <= store_data_r;
        end
    end

    // Port A read sample; sees the pre-write word on a same-edge write
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_pend_r <= 1'b0;
            rd_a_data_r <= {DATA_W{1'b0}};
        end else begin
            rd_a_pend_r <= mem_rd_q;
            if (mem_rd_q) begin
                rd_a_data_r <= mem_r[addr_a_s];
            end
        end
    end

    // Port A data presented on the falling edge, held when no read occurred
    always_ff @(negedge clock or negedge rst_n) begin
        if (!rst_n) begin
            mem_dout <= {DATA_W{1'b0}};
        end else if (rd_a_pend_r) begin
            mem_dout <= rd_a_data_r;
        end
    end

    // Port B read sample; a same-edge port A write to that word is not yet visible
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_b_pend_r <= 1'b0;
            rd_b_data_r <= {DATA_W{1'b0}};
        end else begin
            rd_b_pend_r <= vga_rden;
            if (vga_rden) begin
                rd_b_data_r <= mem_r[addr_b_s];
            end
        end
    end

    // Port B data presented on the falling edge, held when no read occurred
    always_ff @(negedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vga_dout <= {DATA_W{1'b0}};
        end else if (rd_b_pend_r) begin
            vga_dout <= rd_b_data_r;
        end
    end

    assign tie_unused_s = ^{vga_addr[WIDTH-1:MEM_ABITS], mul_full_s[2*WIDTH-1:WIDTH]};

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed-vector bench for exe_mem_stage with queue-based scoreboards for
// the pipeline register and both memory read ports.
module tb_exe_mem_stage;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [15:0] op_a, op_b, imm;
    logic        imm_sel;
    logic [3:0]  alu_sel, destiny;
    logic        write_back, mem_wr, mem_rd;
    logic [15:0] alu_result;
    logic        nop_flag;
    logic [15:0] result_q, dir_mem_q;
    logic [3:0]  destiny_q;
    logic        write_back_q, mem_rd_q, mem_wr_q;
    logic [38:0] exe_mem_out;
    logic [11:0] mem_dout, vga_dout;
    logic [15:0] vga_addr;
    logic        vga_rden;

    int n_cmp = 0;
    int n_err = 0;

    logic [38:0] pipe_q [$];
    logic [11:0] a_q [$];
    logic [11:0] b_q [$];

    exe_mem_stage #(.WIDTH(16), .MEM_ABITS(12)) dut (
        .clock(clock), .rst_n(rst_n),
        .op_a(op_a), .op_b(op_b), .imm(imm), .imm_sel(imm_sel),
        .alu_sel(alu_sel), .destiny(destiny), .write_back(write_back),
        .mem_wr(mem_wr), .mem_rd(mem_rd),
        .alu_result(alu_result), .nop_flag(nop_flag),
        .result_q(result_q), .destiny_q(destiny_q), .write_back_q(write_back_q),
        .mem_rd_q(mem_rd_q), .mem_wr_q(mem_wr_q), .dir_mem_q(dir_mem_q),
        .exe_mem_out(exe_mem_out), .mem_dout(mem_dout),
        .vga_addr(vga_addr), .vga_rden(vga_rden), .vga_dout(vga_dout)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One vector per cycle: drive on the falling edge, queue what the DUT must produce
    task automatic vec(input logic [3:0] sel, input logic isel, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] im, input logic [3:0] dst,
                       input logic wb, input logic wr, input logic rd, input logic vr,
                       input logic [15:0] va, input logic [15:0] e_alu, input logic e_nop,
                       input logic [11:0] e_a, input logic [11:0] e_v);
        @(negedge clock);
        alu_sel = sel; imm_sel = isel; op_a = a; op_b = b; imm = im;
        destiny = dst; write_back = wb; mem_wr = wr; mem_rd = rd;
        vga_rden = vr; vga_addr = va;
        #1;
        check("alu_result", {48'd0, alu_result}, {48'd0, e_alu});
        check("nop_flag", {63'd0, nop_flag}, {63'd0, e_nop});
        pipe_q.push_back({a, wr, rd, wb, dst, e_alu});
        if (rd) a_q.push_back(e_a);
        if (vr) b_q.push_back(e_v);
    endtask

    task automatic alu(input logic [3:0] sel, input logic isel, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] im, input logic [3:0] dst,
                       input logic [15:0] e_alu, input logic e_nop);
        vec(sel, isel, a, b, im, dst, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, e_alu, e_nop, 12'h000, 12'h000);
    endtask

    // Memory vectors use pass-A so the ALU result equals the address
    task automatic mem(input logic [15:0] a, input logic [15:0] b, input logic wr, input logic rd,
                       input logic vr, input logic [15:0] va, input logic [11:0] e_a,
                       input logic [11:0] e_v);
        vec(4'h7, 1'b0, a, b, 16'h0000, 4'h0, 1'b0, wr, rd, vr, va, a, 1'b0, e_a, e_v);
    endtask

    task automatic idle();
        vec(4'hF, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000,
            16'h0000, 1'b1, 12'h000, 12'h000);
    endtask

    // Pipeline monitor: compare the captured register after every rising edge
    initial begin
        logic [38:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (rst_n === 1'b1 && pipe_q.size() > 0) begin
                e = pipe_q.pop_front();
                check("pipe_packed", {25'd0, exe_mem_out}, {25'd0, e});
                check("pipe_ports", {25'd0, dir_mem_q, mem_wr_q, mem_rd_q, write_back_q,
                      destiny_q, result_q}, {25'd0, e});
            end
        end
    end

    // Memory monitor: a read sampled at a rising edge is checked after the next falling edge
    initial begin
        bit a_pend = 1'b0;
        bit b_pend = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            if (a_pend) begin
                if (a_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL port_a_unexpected: got read %h expected none", mem_dout);
                end else begin
                    check("port_a_read", {52'd0, mem_dout}, {52'd0, a_q.pop_front()});
                end
            end
            if (b_pend) begin
                if (b_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL port_b_unexpected: got read %h expected none", vga_dout);
                end else begin
                    check("port_b_read", {52'd0, vga_dout}, {52'd0, b_q.pop_front()});
                end
            end
            a_pend = (rst_n === 1'b1) && (mem_rd_q === 1'b1);
            b_pend = (rst_n === 1'b1) && (vga_rden === 1'b1);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        op_a = 16'h1111; op_b = 16'h0222; imm = 16'h0000; imm_sel = 1'b0;
        alu_sel = 4'h0; destiny = 4'h3; write_back = 1'b1; mem_wr = 1'b1; mem_rd = 1'b1;
        vga_addr = 16'h0000; vga_rden = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_pipe", {25'd0, exe_mem_out}, 64'd0);
        check("reset_mem_dout", {52'd0, mem_dout}, 64'd0);
        check("reset_vga_dout", {52'd0, vga_dout}, 64'd0);
        repeat (2) @(posedge clock);
        #1;
        check("reset_hold_pipe", {25'd0, exe_mem_out}, 64'd0);
        @(negedge clock);
        mem_wr = 1'b0; mem_rd = 1'b0; alu_sel = 4'hF;
        rst_n = 1'b1;

        // ALU coverage
        alu(4'h0, 1'b0, 16'h0003, 16'h0004, 16'h0000, 4'h1, 16'h0007, 1'b0);
        alu(4'h1, 1'b0, 16'h0005, 16'h0007, 16'h0000, 4'h2, 16'hFFFE, 1'b0);
        alu(4'hF, 1'b0, 16'h0005, 16'h0007, 16'h0000, 4'h3, 16'h0000, 1'b1);
        alu(4'h0, 1'b1, 16'h1234, 16'h0001, 16'h0010, 4'h4, 16'h0011, 1'b0);
        alu(4'h2, 1'b0, 16'hF0F0, 16'hFF00, 16'h0000, 4'h5, 16'hF000, 1'b0);
        alu(4'h3, 1'b0, 16'hF0F0, 16'h0F0F, 16'h0000, 4'h6, 16'hFFFF, 1'b0);
        alu(4'h4, 1'b0, 16'hAAAA, 16'hFFFF, 16'h0000, 4'h7, 16'h5555, 1'b0);
        alu(4'h5, 1'b0, 16'h0001, 16'h0013, 16'h0000, 4'h8, 16'h0008, 1'b0);
        alu(4'h5, 1'b0, 16'h0003, 16'h001F, 16'h0000, 4'h9, 16'h8000, 1'b0);
        alu(4'h6, 1'b0, 16'h8000, 16'h000F, 16'h0000, 4'hA, 16'h0001, 1'b0);
        alu(4'h6, 1'b0, 16'hF000, 16'h0004, 16'h0000, 4'hB, 16'h0F00, 1'b0);
        alu(4'h7, 1'b0, 16'h1357, 16'h2468, 16'h0000, 4'hC, 16'h1357, 1'b0);
        alu(4'h7, 1'b1, 16'h1357, 16'h2468, 16'hABCD, 4'hD, 16'hABCD, 1'b0);
        alu(4'h8, 1'b0, 16'h1357, 16'h2468, 16'h0000, 4'hE, 16'h2468, 1'b0);
        alu(4'h9, 1'b0, 16'h0100, 16'h0100, 16'h0000, 4'hF, 16'h0000, 1'b0);
        alu(4'h9, 1'b0, 16'h00FF, 16'h0003, 16'h0000, 4'h1, 16'h02FD, 1'b0);
        alu(4'hA, 1'b0, 16'h0001, 16'h0001, 16'h0000, 4'h2, 16'h0000, 1'b1);
        alu(4'h0, 1'b0, 16'hFFFF, 16'h0002, 16'h0000, 4'h3, 16'h0001, 1'b0);

        // Memory: stores, wrapped address, loads, read-before-write on both ports
        mem(16'h0005, 16'h0ABC, 1'b1, 1'b0, 1'b0, 16'h0000, 12'h000, 12'h000);
        mem(16'h1006, 16'hF123, 1'b1, 1'b0, 1'b0, 16'h0000, 12'h000, 12'h000);
        mem(16'h0007, 16'h0111, 1'b1, 1'b0, 1'b0, 16'h0000, 12'h000, 12'h000);
        mem(16'h0005, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0005, 12'hABC, 12'hABC);
        mem(16'h0006, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hF006, 12'h123, 12'h123);
        mem(16'h0007, 16'h0777, 1'b1, 1'b0, 1'b0, 16'h0000, 12'h000, 12'h000);
        mem(16'h0005, 16'h0555, 1'b1, 1'b1, 1'b1, 16'h0007, 12'hABC, 12'h111);
        mem(16'h0005, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0007, 12'h555, 12'h777);
        mem(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0005, 12'h000, 12'h555);
        idle(); idle(); idle();
        check("mem_dout_hold", {52'd0, mem_dout}, {52'd0, 12'h555});
        check("vga_dout_hold", {52'd0, vga_dout}, {52'd0, 12'h555});

        // Reset with a store pending: outputs clear at once and the word survives
        mem(16'h0009, 16'h0321, 1'b1, 1'b0, 1'b0, 16'h0000, 12'h000, 12'h000);
        idle(); idle();
        mem(16'h0009, 16'h0999, 1'b1, 1'b0, 1'b0, 16'h0000, 12'h000, 12'h000);
        @(posedge clock);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_pipe", {25'd0, exe_mem_out}, 64'd0);
        check("midreset_mem_dout", {52'd0, mem_dout}, 64'd0);
        check("midreset_vga_dout", {52'd0, vga_dout}, 64'd0);
        mem_wr = 1'b0; alu_sel = 4'hF;
        repeat (2) @(posedge clock);
        #1;
        check("midreset_hold", {25'd0, exe_mem_out}, 64'd0);
        @(posedge clock);
        #3;
        rst_n = 1'b1;
        mem(16'h0009, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0009, 12'h321, 12'h321);
        alu(4'h0, 1'b0, 16'h0003, 16'h0004, 16'h0000, 4'h6, 16'h0007, 1'b0);
        idle(); idle();

        for (int i = 0; i < 20; i++) begin
            if (pipe_q.size() == 0 && a_q.size() == 0 && b_q.size() == 0) break;
            @(posedge clock);
        end
        #8;
        if (pipe_q.size() != 0 || a_q.size() != 0 || b_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: got %0d/%0d/%0d pending expected 0/0/0",
                     pipe_q.size(), a_q.size(), b_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
